// File: rtl/bcd_to_bin11_pkg.sv
// Shared constants, state encoding and digit-check helper for the
// four-digit BCD to 11-bit binary converter.
package bcd_to_bin11_pkg;

  localparam int unsigned BIN_W   = 11;
  localparam int unsigned NDIG    = 4;
  localparam int unsigned ITER    = 14;
  localparam int unsigned BIN_MAX = 2047;

  localparam int unsigned BCD_W = 4 * NDIG;
  // 14 bits hold 9999, the largest decimal value four digits can express
  localparam int unsigned ACC_W = ITER;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  function automatic logic bad_digit(input logic [BCD_W-1:0] bcd);
    bad_digit = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/bcd_to_bin11_if.sv
// Handshake and data bundle between a BCD producer, the converter and the
// downstream consumer of the binary result.
interface bcd_to_bin11_if;
  import bcd_to_bin11_pkg::*;

  logic [3:0]       thousands;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] bin;
  logic             ovf;
  logic             err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output thousands, hundreds, tens, ones, in_valid, out_ready,
    input  in_ready, bin, ovf, err, out_valid
  );

  modport slave (
    input  thousands, hundreds, tens, ones, in_valid, out_ready,
    output in_ready, bin, ovf, err, out_valid
  );

endinterface

// File: rtl/sub3.sv
// Reverse double-dabble digit correction: subtract 3 from a shifted BCD
// digit whose value is 8 or more.
module sub3 (
  input  logic [3:0] num,
  output logic [3:0] out
);

  always_comb begin
    out = num;
    if (num >= 4'd8) out = num - 4'd3;
  end

endmodule

// File: rtl/bcd_to_bin11.sv
// Iterative BCD to binary converter: 14 shift/correct steps plus one
// result cycle, so every conversion takes exactly 15 cycles.
module bcd_to_bin11
  import bcd_to_bin11_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  bcd_to_bin11_if.slave bus
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER);
  localparam logic [ACC_W-1:0] AccMax   = ACC_W'(BIN_MAX);

  state_e                 state_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [BCD_W-1:0]       bcd_fix;
  logic [ACC_W-1:0]       acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   err_int_q;
  logic [BIN_W-1:0]       bin_q;
  logic                   ovf_q;
  logic                   err_q;
  logic [BCD_W+ACC_W-1:0] shifted;

  assign shifted = {bcd_q, acc_q} >> 1;

  for (genvar i = 0; i < int'(NDIG); i++) begin : g_fix
    sub3 u_sub3 (
      .num (shifted[ACC_W+4*i +: 4]),
      .out (bcd_fix[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_int_q <= 1'b0;
      bin_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bcd_q     <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
            acc_q     <= '0;
            cnt_q     <= '0;
            err_int_q <= bad_digit({bus.thousands, bus.hundreds, bus.tens, bus.ones});
            state_q   <= CONV;
          end
        end
        CONV: begin
          if (cnt_q == LastIter) begin
            state_q <= DONE;
            if (err_int_q) begin
              bin_q <= '0;
              ovf_q <= 1'b0;
              err_q <= 1'b1;
            end else if (acc_q > AccMax) begin
              bin_q <= '1;
              ovf_q <= 1'b1;
              err_q <= 1'b0;
            end else begin
              bin_q <= acc_q[BIN_W-1:0];
              ovf_q <= 1'b0;
              err_q <= 1'b0;
            end
          end else begin
            bcd_q <= bcd_fix;
            acc_q <= shifted[ACC_W-1:0];
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin       = bin_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin11.sv
// Directed bench for bcd_to_bin11 with an expected-result queue filled at
// each input handshake and drained when out_valid appears.
module tb_bcd_to_bin11;

  typedef struct packed {
    logic [10:0] bin;
    logic        ovf;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  bcd_to_bin11_if bus ();

  bcd_to_bin11 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] th, input logic [3:0] h,
                                 input logic [3:0] t, input logic [3:0] o);
    exp_t e;
    int   v;
    v = int'(th) * 1000 + int'(h) * 100 + int'(t) * 10 + int'(o);
    if (th > 4'd9 || h > 4'd9 || t > 4'd9 || o > 4'd9) e = '{bin: 11'd0, ovf: 1'b0, err: 1'b1};
    else if (v > 2047) e = '{bin: 11'h7FF, ovf: 1'b1, err: 1'b0};
    else e = '{bin: v[10:0], ovf: 1'b0, err: 1'b0};
    return e;
  endfunction

  // One conversion: handshake, latency check, result check, optional hold
  // with out_ready low, then the output handshake.
  task automatic xfer(input logic [3:0] th, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o, input int hold, input bit junk);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.out_ready = (hold == 0);
    bus.thousands = th;
    bus.hundreds  = h;
    bus.tens      = t;
    bus.ones      = o;
    bus.in_valid  = 1'b1;
    sb.push_back(model(th, h, t, o));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("in_ready_busy", bus.in_ready, 0);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      if (junk) begin
        bus.in_valid  = cyc[0];
        bus.thousands = 4'd9;
        bus.ones      = 4'd9;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("latency", cyc, 15);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("bin", bus.bin, e.bin);
    chk("ovf", bus.ovf, e.ovf);
    chk("err", bus.err, e.err);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = junk;
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_bin", bus.bin, e.bin);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", bus.out_valid, 0);
    chk("after_bin", bus.bin, e.bin);
    chk("after_flags", {bus.ovf, bus.err}, {e.ovf, e.err});
    chk("ready_again", bus.in_ready, 1);
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_bad = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.thousands = 4'd0;
    bus.hundreds  = 4'd0;
    bus.tens      = 4'd0;
    bus.ones      = 4'd0;

    #2 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_bin", bus.bin, 0);
    chk("rst_flags", {bus.ovf, bus.err}, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    xfer(4'd0, 4'd0, 4'd0, 4'd0, 0, 0);
    xfer(4'd2, 4'd0, 4'd4, 4'd7, 0, 0);
    xfer(4'd9, 4'd9, 4'd9, 4'd9, 0, 0);
    xfer(4'd2, 4'd0, 4'd4, 4'd8, 0, 0);
    xfer(4'd1, 4'hA, 4'd3, 4'd4, 0, 0);
    xfer(4'd1, 4'd2, 4'd3, 4'd4, 10, 1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no_extra_result", seen, 0);

    // Abort 5000 mid-conversion; bin still shows 1234 until reset hits.
    bus.thousands = 4'd5;
    bus.hundreds  = 4'd0;
    bus.tens      = 4'd0;
    bus.ones      = 4'd0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_bin", bus.bin, 0);
    chk("abort_flags", {bus.ovf, bus.err}, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    xfer(4'd0, 4'd0, 4'd4, 4'd2, 0, 0);

    for (int v = 0; v <= 2047; v++) begin
      xfer(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), 0, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
